udp_reply_tx: RTL and testbench

//  Builds and transmits one Ethernet/IPv4/UDP reply frame per start pulse as a byte AXI-stream into the MAC TX port.

---
 rtl/udp_reply_tx_if.sv | 22 ++
 rtl/udp_reply_tx.sv | 226 ++++++++++++++++++++++
 tb/tb_udp_reply_tx.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_reply_tx_if.sv
// Byte stream towards the MAC plus the 32-bit word source feeding it.
// The frame builder is the master; MAC and word source sit on the slave side.
interface udp_reply_tx_if;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic [31:0] txd;
  logic        txvld;
  logic        txend;
  logic        txready;

  modport master (
    output tdata, tvalid, tlast, txready,
    input  tready, txd, txvld, txend
  );

  modport slave (
    input  tdata, tvalid, tlast, txready,
    output tready, txd, txvld, txend
  );
endinterface

// File: rtl/udp_reply_tx.sv
// Ethernet/IPv4/UDP reply frame builder: header, echoed command words,
// streamed data words and zero padding, sent as a byte stream.
module udp_reply_tx #(
  parameter int         MAX_WORDS = 360,
  parameter int         NW_W      = 9,
  parameter logic [7:0] TTL       = 8'h40
) (
  input  logic            clk125,
  input  logic            reset_n,
  input  logic [47:0]     MAC,
  input  logic [31:0]     IP,
  input  logic            start,
  input  logic [47:0]     dst_mac,
  input  logic [31:0]     dst_ip,
  input  logic [15:0]     src_port,
  input  logic [15:0]     dst_port,
  input  logic [31:0]     hdr_cmd,
  input  logic [31:0]     hdr_adr,
  input  logic [31:0]     hdr_val,
  input  logic [NW_W-1:0] nwords,
  output logic            busy,
  output logic            err,
  udp_reply_tx_if.master  bus
);

  localparam logic [NW_W-1:0] MAXW   = NW_W'(MAX_WORDS);
  localparam logic [NW_W-1:0] NW_ONE = NW_W'(1);

  typedef enum logic [2:0] {
    IDLE, CSUM, HDR, DATA, PAD, DONE
  } state_t;

  state_t          state;
  logic [47:0]     dmac;
  logic [31:0]     dip;
  logic [15:0]     sport;
  logic [15:0]     dport;
  logic [31:0]     cmd;
  logic [31:0]     adr;
  logic [31:0]     val;
  logic [NW_W-1:0] n;
  logic [NW_W-1:0] words_left;
  logic [15:0]     ip_id;
  logic [19:0]     sum;
  logic [3:0]      cnt;
  logic [10:0]     idx;
  logic [431:0]    hsr;
  logic [31:0]     wbuf;
  logic [2:0]      bcnt;
  logic            zfill;

  logic [15:0]  ip_len;
  logic [15:0]  udp_len;
  logic [10:0]  data_end;
  logic [10:0]  last_idx;
  logic [15:0]  hw;
  logic [19:0]  sum_nxt;
  logic [16:0]  fold1;
  logic [15:0]  fold2;
  logic [15:0]  csum;
  logic [431:0] hdr_vec;
  logic         load;

  assign ip_len   = 16'd40 + 16'({n, 2'b00});
  assign udp_len  = 16'd20 + 16'({n, 2'b00});
  assign data_end = 11'd53 + 11'({n, 2'b00});
  assign last_idx = (data_end < 11'd59) ? 11'd59 : data_end;

  always_comb begin
    hw = 16'h0000;
    case (cnt)
      4'd0:    hw = 16'h4500;
      4'd1:    hw = ip_len;
      4'd2:    hw = ip_id;
      4'd3:    hw = 16'h4000;
      4'd4:    hw = {TTL, 8'h11};
      4'd6:    hw = IP[31:16];
      4'd7:    hw = IP[15:0];
      4'd8:    hw = dip[31:16];
      4'd9:    hw = dip[15:0];
      default: hw = 16'h0000;
    endcase
  end

  assign sum_nxt = sum + {4'd0, hw};
  assign fold1   = {1'b0, sum_nxt[15:0]} + {13'd0, sum_nxt[19:16]};
  assign fold2   = fold1[15:0] + {15'd0, fold1[16]};
  assign csum    = ~fold2;

  // Whole 54-byte header, shifted out MSB first during HDR
  assign hdr_vec = {
    dmac, MAC, 16'h0800,
    16'h4500, ip_len, ip_id, 16'h4000, TTL, 8'h11, csum, IP, dip,
    sport, dport, udp_len, 16'h0000,
    cmd, adr, val
  };

  assign load = !bus.tvalid || bus.tready;

  assign bus.txready = (state == DATA) && (bcnt == 3'd0) &&
                       (words_left != '0) && !zfill;

  always_ff @(posedge clk125 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      err        <= 1'b0;
      bus.tdata  <= 8'h00;
      bus.tvalid <= 1'b0;
      bus.tlast  <= 1'b0;
      dmac       <= '0;
      dip        <= '0;
      sport      <= '0;
      dport      <= '0;
      cmd        <= '0;
      adr        <= '0;
      val        <= '0;
      n          <= '0;
      words_left <= '0;
      ip_id      <= '0;
      sum        <= '0;
      cnt        <= '0;
      idx        <= '0;
      hsr        <= '0;
      wbuf       <= '0;
      bcnt       <= '0;
      zfill      <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dmac  <= dst_mac;
            dip   <= dst_ip;
            sport <= src_port;
            dport <= dst_port;
            cmd   <= hdr_cmd;
            adr   <= hdr_adr;
            val   <= hdr_val;
            n     <= (nwords > MAXW) ? MAXW : nwords;
            err   <= (nwords > MAXW);
            busy  <= 1'b1;
            sum   <= '0;
            cnt   <= '0;
            state <= CSUM;
          end
        end
        CSUM: begin
          sum <= sum_nxt;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd9) begin
            hsr   <= hdr_vec;
            idx   <= '0;
            state <= HDR;
          end
        end
        HDR: begin
          if (load) begin
            bus.tdata  <= hsr[431:424];
            bus.tvalid <= 1'b1;
            hsr        <= {hsr[423:0], 8'h00};
            idx        <= idx + 11'd1;
            if (idx == 11'd53) begin
              words_left <= n;
              bcnt       <= '0;
              zfill      <= 1'b0;
              state      <= (n != '0) ? DATA : PAD;
            end
          end
        end
        DATA: begin
          if (bcnt == 3'd0) begin
            if (load)
              bus.tvalid <= 1'b0;
            if (bus.txvld && bus.txready) begin
              wbuf       <= bus.txd;
              bcnt       <= 3'd4;
              words_left <= words_left - NW_ONE;
              // Early end: the rest of the frame is all zeros anyway
              if (bus.txend && words_left > NW_ONE) begin
                err   <= 1'b1;
                zfill <= 1'b1;
              end
            end
          end else if (load) begin
            bus.tdata  <= wbuf[31:24];
            bus.tvalid <= 1'b1;
            wbuf       <= {wbuf[23:0], 8'h00};
            bcnt       <= bcnt - 3'd1;
            idx        <= idx + 11'd1;
            if (idx == last_idx) begin
              bus.tlast <= 1'b1;
              state     <= DONE;
            end else if (bcnt == 3'd1 &&
                         (words_left == '0 || zfill)) begin
              state <= PAD;
            end
          end
        end
        PAD: begin
          if (load) begin
            bus.tdata  <= 8'h00;
            bus.tvalid <= 1'b1;
            idx        <= idx + 11'd1;
            if (idx == last_idx) begin
              bus.tlast <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.tready) begin
            bus.tdata  <= 8'h00;
            bus.tvalid <= 1'b0;
            bus.tlast  <= 1'b0;
            busy       <= 1'b0;
            ip_id      <= ip_id + 16'd1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_reply_tx.sv
// Directed and randomized frames for udp_reply_tx, checked against a
// byte-level frame model built from the protocol field layout.
module tb_udp_reply_tx;

  localparam logic [47:0] OUR_MAC = 48'h02_00_00_00_00_01;
  localparam logic [31:0] OUR_IP  = {8'd192, 8'd168, 8'd10, 8'd2};

  logic        clk125;
  logic        reset_n;
  logic        start;
  logic [47:0] dst_mac;
  logic [31:0] dst_ip;
  logic [15:0] src_port;
  logic [15:0] dst_port;
  logic [31:0] hdr_cmd;
  logic [31:0] hdr_adr;
  logic [31:0] hdr_val;
  logic [8:0]  nwords;
  logic        busy;
  logic        err;

  udp_reply_tx_if bus();

  udp_reply_tx dut (
    .clk125   (clk125),
    .reset_n  (reset_n),
    .MAC      (OUR_MAC),
    .IP       (OUR_IP),
    .start    (start),
    .dst_mac  (dst_mac),
    .dst_ip   (dst_ip),
    .src_port (src_port),
    .dst_port (dst_port),
    .hdr_cmd  (hdr_cmd),
    .hdr_adr  (hdr_adr),
    .hdr_val  (hdr_val),
    .nwords   (nwords),
    .busy     (busy),
    .err      (err),
    .bus      (bus)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [8:0]  rx[$];
  logic [8:0]  exp_q[$];
  bit   [31:0] src_words[$];
  int          src_end = -1;
  int          src_idx = 0;
  bit          gap_en = 0;
  int          tr_mode = 0;
  int          err_cnt = 0;
  int          exp_err;
  int          exp_acc;
  logic [15:0] model_id = 16'd0;

  initial begin
    clk125 = 1'b0;
    forever #4 clk125 = ~clk125;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [8:0] rxb(input int i);
    if (i < rx.size()) return rx[i];
    return 9'bx;
  endfunction

  function automatic void pb(input logic [63:0] v, input int nb);
    for (int i = nb - 1; i >= 0; i--)
      exp_q.push_back({1'b0, v[8*i +: 8]});
  endfunction

  // Reference frame from the field layout and the words the source offers
  task automatic build(input int nw);
    int          n;
    int          s;
    logic [15:0] hw[10];
    logic [15:0] cs;
    logic [8:0]  t;
    n = (nw > 360) ? 360 : nw;
    exp_q.delete();
    hw = '{16'h4500, 16'(40 + 4*n), model_id, 16'h4000, 16'h4011,
           16'h0000, OUR_IP[31:16], OUR_IP[15:0],
           dst_ip[31:16], dst_ip[15:0]};
    s = 0;
    foreach (hw[i]) s += int'(hw[i]);
    while (s > 65535) s = (s & 65535) + (s >> 16);
    cs = ~16'(s);
    pb(dst_mac, 6); pb(OUR_MAC, 6); pb(16'h0800, 2);
    pb(16'h4500, 2); pb(40 + 4*n, 2); pb(model_id, 2);
    pb(16'h4000, 2); pb(16'h4011, 2); pb(cs, 2);
    pb(OUR_IP, 4); pb(dst_ip, 4);
    pb(src_port, 2); pb(dst_port, 2); pb(20 + 4*n, 2); pb(0, 2);
    pb(hdr_cmd, 4); pb(hdr_adr, 4); pb(hdr_val, 4);
    for (int i = 0; i < n; i++)
      pb((src_end >= 0 && i > src_end) ? 32'h0 : src_words[i], 4);
    while (exp_q.size() < 60) pb(0, 1);
    t = exp_q.pop_back();
    exp_q.push_back(t | 9'h100);
    exp_err = ((nw > 360) ? 1 : 0) +
              ((src_end >= 0 && src_end < n - 1) ? 1 : 0);
    exp_acc = (src_end >= 0 && src_end < n) ? src_end + 1 : n;
  endtask

  task automatic rand_cfg();
    dst_mac  = {16'($urandom), $urandom};
    dst_ip   = $urandom;
    src_port = 16'($urandom);
    dst_port = 16'($urandom);
    hdr_cmd  = $urandom;
    hdr_adr  = $urandom;
    hdr_val  = $urandom;
  endtask

  task automatic set_src(input int cnt, input int endpos);
    src_words.delete();
    for (int i = 0; i < cnt; i++) src_words.push_back($urandom);
    src_end = endpos;
  endtask

  task automatic launch(input int nw, input bit restart);
    int lat;
    build(nw);
    @(negedge clk125);
    nwords  = 9'(nw);
    src_idx = 0;
    err_cnt = 0;
    rx.delete();
    start   = 1'b1;
    @(negedge clk125);
    start = 1'b0;
    chk("busy_set", busy, 1);
    lat = 0;
    while (!bus.tvalid && lat < 40) begin
      @(negedge clk125);
      lat++;
    end
    chk("latency", lat, 11);
    if (restart) begin
      @(negedge clk125);
      dst_mac = ~dst_mac;
      nwords  = 9'd5;
      start   = 1'b1;
      @(negedge clk125);
      start = 1'b0;
    end
  endtask

  task automatic finish_frame();
    int c;
    c = 0;
    while (busy && c < 20000) begin
      @(negedge clk125);
      c++;
    end
    chk("busy_clear", busy, 0);
    chk("frame_len", rx.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("byte%0d", i), rxb(i), exp_q[i]);
      if (rxb(i) !== exp_q[i]) break;
    end
    chk("err_pulses", err_cnt, exp_err);
    chk("words_taken", src_idx, exp_acc);
    model_id++;
    repeat (3) @(negedge clk125);
    chk("idle_tvalid", bus.tvalid, 0);
    chk("idle_busy", busy, 0);
  endtask

  // Word source: holds a word until it is taken, optional random gaps
  initial begin
    bit hs;
    bus.txvld = 1'b0;
    bus.txd   = 32'h0;
    bus.txend = 1'b0;
    forever begin
      @(negedge clk125);
      hs = bus.txvld && bus.txready;
      @(posedge clk125);
      #1;
      if (hs) src_idx++;
      if (src_idx < src_words.size() &&
          (!gap_en || $urandom_range(0, 2) != 0)) begin
        bus.txvld = 1'b1;
        bus.txd   = src_words[src_idx];
        bus.txend = (src_idx == src_end);
      end else begin
        bus.txvld = 1'b0;
        bus.txd   = 32'h0;
        bus.txend = 1'b0;
      end
    end
  end

  initial begin
    bus.tready = 1'b1;
    forever begin
      @(posedge clk125);
      #1;
      case (tr_mode)
        0:       bus.tready = 1'b1;
        1:       bus.tready = !bus.tready;
        default: bus.tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Byte capture, stall stability and err pulse counting
  initial begin
    bit         pend;
    logic [8:0] pv;
    pend = 1'b0;
    pv   = 9'h0;
    forever begin
      @(negedge clk125);
      if (!reset_n) begin
        pend = 1'b0;
      end else begin
        if (pend)
          chk("stall_hold", {bus.tvalid, bus.tlast, bus.tdata}, {1'b1, pv});
        if (bus.tvalid && bus.tready)
          rx.push_back({bus.tlast, bus.tdata});
        if (err) err_cnt++;
        pend = bus.tvalid && !bus.tready;
        pv   = {bus.tlast, bus.tdata};
      end
    end
  end

  initial begin
    int c;
    reset_n  = 1'b0;
    start    = 1'b0;
    nwords   = 9'd0;
    dst_mac  = 48'h0A_0B_0C_0D_0E_0F;
    dst_ip   = {8'd192, 8'd168, 8'd10, 8'd1};
    src_port = 16'd7000;
    dst_port = 16'd7001;
    hdr_cmd  = 32'h8000_0012;
    hdr_adr  = 32'h0000_1000;
    hdr_val  = 32'h0000_0000;
    repeat (3) @(negedge clk125);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_tvalid", bus.tvalid, 0);
    chk("rst_tlast", bus.tlast, 0);
    chk("rst_tdata", bus.tdata, 0);
    chk("rst_txready", bus.txready, 0);
    reset_n = 1'b1;

    // Empty payload: minimum frame, all padding
    set_src(0, -1);
    launch(0, 0);
    finish_frame();
    chk("ip_len_hi", rxb(16), 9'h000);
    chk("ip_len_lo", rxb(17), 9'h028);
    chk("udp_len_hi", rxb(38), 9'h000);
    chk("udp_len_lo", rxb(39), 9'h014);
    chk("pad58", rxb(58), 9'h000);
    chk("pad59_last", rxb(59), 9'h100);

    // Four words, txend on the last one
    src_words = '{32'h11223344, 32'h22334455, 32'h33445566, 32'h44556677};
    src_end   = 3;
    launch(4, 0);
    finish_frame();
    chk("len70", rx.size(), 70);
    chk("ipid_lo", rxb(19), 9'h001);
    chk("iplen_lo4", rxb(17), 9'h038);
    chk("data_first", rxb(54), 9'h011);
    chk("data_last", rxb(69), 9'h177);

    // Early txend on word 0 of 3
    gap_en = 1'b1;
    set_src(3, 0);
    launch(3, 0);
    finish_frame();
    chk("len66", rx.size(), 66);

    // Toggling tready with source gaps
    tr_mode = 1;
    rand_cfg();
    c = $urandom_range(1, 24);
    set_src(c + 2, -1);
    launch(c, 0);
    finish_frame();

    // Random frames, random backpressure, random txend position
    tr_mode = 2;
    for (int k = 0; k < 5; k++) begin
      rand_cfg();
      c = $urandom_range(0, 40);
      set_src(c + 2, $urandom_range(0, c + 2) - 1);
      launch(c, 0);
      finish_frame();
    end

    // Oversized request, clamped; second start during the frame
    rand_cfg();
    set_src(400, 399);
    launch(400, 1);
    finish_frame();
    chk("len1494", rx.size(), 1494);
    chk("clamp_len_hi", rxb(16), 9'h005);
    chk("clamp_len_lo", rxb(17), 9'h0C8);

    // Reset in the middle of a frame
    tr_mode = 0;
    gap_en  = 1'b0;
    rand_cfg();
    set_src(12, -1);
    launch(10, 0);
    c = 0;
    while (rx.size() < 30 && c < 1000) begin
      @(negedge clk125);
      c++;
    end
    chk("reach_byte30", rx.size() >= 30, 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", bus.tvalid, 0);
    chk("mid_rst_tlast", bus.tlast, 0);
    chk("mid_rst_tdata", bus.tdata, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_txready", bus.txready, 0);
    repeat (2) @(negedge clk125);
    reset_n  = 1'b1;
    model_id = 16'd0;
    launch(10, 0);
    finish_frame();
    chk("post_rst_ipid", {rxb(18), rxb(19)}, 18'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
